// File: rtl/uart_rx_byte.sv
// Byte-level 8N1 UART receiver, LSB first, mid-bit sampling with a 2-flop rx synchroniser.
// Optional 2-of-3 majority vote on the bit sample when UART_RX_MAJORITY_EN is defined.
module uart_rx_byte #(
  parameter int clock_frequency = 50000000,
  parameter int baud_rate       = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int divisor = clock_frequency / baud_rate;
  localparam int half    = divisor / 2;
  localparam logic [15:0] start_strobe = 16'(half - 1);
  localparam logic [15:0] bit_strobe   = 16'(divisor - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t      state;
  logic        s1;
  logic        rx_s;
  logic [15:0] count;
  logic [2:0]  index;
  logic [7:0]  shift;
  logic        sample;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is rx_s one cycle back, hist[1] two cycles back; vote adds no latency
  logic [1:0] hist;

  always_ff @(posedge clock) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end

  always_comb begin
    sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
  end
`else
  always_comb begin
    sample = rx_s;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      count         <= 16'd0;
      index         <= 3'd0;
      shift         <= 8'h00;
      data          <= 8'h00;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      valid         <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            count <= 16'd0;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (count == start_strobe) begin
            count <= 16'd0;
            if (!sample) begin
              state <= ST_DATA;
              index <= 3'd0;
            end else begin
              // start bit vanished before mid-bit: treat as a glitch
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            count <= count + 16'd1;
          end
        end
        ST_DATA: begin
          if (count == bit_strobe) begin
            count        <= 16'd0;
            shift[index] <= sample;
            if (index == 3'd7) state <= ST_STOP;
            else               index <= index + 3'd1;
          end else begin
            count <= count + 16'd1;
          end
        end
        ST_STOP: begin
          if (count == bit_strobe) begin
            count <= 16'd0;
            data  <= shift;
            if (sample) begin
              valid <= 1'b1;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              state         <= ST_BREAK;
            end
          end else begin
            count <= count + 16'd1;
          end
        end
        ST_BREAK: begin
          // hold off start detection until the line releases from a break
          if (rx_s) begin
            state <= ST_IDLE;
            count <= 16'd0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= 16'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at default parameters (divisor 434, half 217).
// Inputs are driven on the falling edge; a monitor logs strobes against a rising-edge counter.
module tb_uart_rx_byte;

  localparam int DIV  = 434;
  localparam int HALF = 217;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_fe = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic [7:0] last_valid_data = 8'h00;
  logic [7:0] prev_valid_data = 8'h00;
  logic       busy_at_valid = 1'b1;

  uart_rx_byte dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data          (data),
    .valid         (valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid) begin
      n_valid         = n_valid + 1;
      prev_valid_cyc  = last_valid_cyc;
      prev_valid_data = last_valid_data;
      last_valid_cyc  = cyc;
      last_valid_data = data;
      busy_at_valid   = busy;
    end
    if (framing_error) n_fe = n_fe + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Full frame driven cycle by cycle; glitch_at forces rx low for one cycle at that offset.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10 * DIV; k++) begin
      rx = (k == glitch_at) ? 1'b0 : bits[k / DIV];
      @(negedge clock);
    end
  endtask

  initial begin
    int start;
    int nv;
    int nf;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ferr", {31'd0, framing_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    idle(20);

    // 0x55: stop strobe at t0+4125, t0 is the edge after the start-bit drive
    start = cyc;
    send_frame(8'h55, 1'b1, -1);
    idle(50);
    check("f55_count", n_valid, 1);
    check("f55_timing", last_valid_cyc, start + 1 + 4125);
    check("f55_data", {24'd0, last_valid_data}, 32'h55);
    check("f55_busy_falls", {31'd0, busy_at_valid}, 32'd0);
    check("f55_ferr", n_fe, 0);

    // 100-cycle low pulse: START rejects it at t0+2+half
    start = cyc;
    rx = 1'b0;
    repeat (100) @(negedge clock);
    rx = 1'b1;
    repeat (119) @(negedge clock);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    idle(200);
    check("glitch_no_valid", n_valid, 1);
    check("glitch_no_ferr", n_fe, 0);
    send_frame(8'hA3, 1'b1, -1);
    idle(50);
    check("fa3_count", n_valid, 2);
    check("fa3_data", {24'd0, data}, 32'hA3);

    // 0x3C with a zero stop bit followed by a long break
    send_frame(8'h3C, 1'b0, -1);
    rx = 1'b0;
    repeat (2000) @(negedge clock);
    check("brk_ferr", n_fe, 1);
    check("brk_data", {24'd0, data}, 32'h3C);
    check("brk_no_valid", n_valid, 2);
    check("brk_busy", {31'd0, busy}, 32'd1);
    idle(3);
    check("brk_busy_exit", {31'd0, busy}, 32'd0);
    idle(1000);
    check("brk_no_spurious_v", n_valid, 2);
    check("brk_no_spurious_f", n_fe, 1);

    // back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(50);
    check("b2b_count", n_valid, 4);
    check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 4340);
    check("b2b_first", {24'd0, prev_valid_data}, 32'h00);
    check("b2b_second", {24'd0, last_valid_data}, 32'hFF);

    // reset in the middle of data bit 3 of 0xA5
    nv = n_valid;
    nf = n_fe;
    rx = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1) ? 1'b0 : 1'b1;
      repeat (DIV) @(negedge clock);
    end
    rx = 1'b0;
    repeat (HALF) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    rx = 1'b1;
    check("rst_mid_data", {24'd0, data}, 32'h00);
    check("rst_mid_valid", {31'd0, valid}, 32'd0);
    check("rst_mid_ferr", {31'd0, framing_error}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    idle(3000);
    check("rst_no_strobe", (n_valid - nv) + (n_fe - nf), 0);
    send_frame(8'h81, 1'b1, -1);
    idle(50);
    check("f81_count", n_valid, nv + 1);
    check("f81_data", {24'd0, data}, 32'h81);

    // one-cycle low on rx_s exactly at the bit-2 sample edge of 0xFF
    send_frame(8'hFF, 1'b1, HALF + 3 * DIV);
    idle(50);
    check("vote_count", n_valid, nv + 2);
`ifdef UART_RX_MAJORITY_EN
    check("vote_data", {24'd0, data}, 32'hFF);
`else
    check("vote_data", {24'd0, data}, 32'hFB);
`endif
    check("final_ferr", n_fe, nf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Byte-level UART receiver, 8N1, LSB first. Sits directly downstream of the rx line sampling stage on the board's GPIO UART input. Synchronises the raw rx pin, detects the start bit, samples each bit at mid-bit, and delivers one byte per frame with a single-cycle valid strobe and a framing-error strobe. Its outputs feed the byte consumer and the board's debug counters and displays.

## Interface
- clock_frequency, 50000000: clock frequency in Hz.
- baud_rate, 115200: line rate in baud.
- Derived, not overridable:
  - divisor = clock_frequency / baud_rate, integer truncation (434 at defaults).
  - half = divisor / 2, truncation (217).
  - Legal range: 4 ≤ divisor ≤ 65535; the bit counter is 16 bits.
- Ports:
  - clock  in  1  the single clock; all logic is on its rising edge.
  - reset  in  1  synchronous, active-high reset.
  - rx  in  1  raw asynchronous UART line; idle is 1.
  - data  out  8  last received byte; holds its value between frames.
  - valid  out  1  one-cycle pulse when data updates with a good frame.
  - framing_error  out  1  one-cycle pulse when the stop bit samples as 0.
  - busy  out  1  high whenever the state is not IDLE.

## Operation
- Synchroniser: two flops, rx → s1 → rx_s, both reset to 1. The FSM sees only rx_s.
- Bit sample value: rx_s. With the configuration macro, it is a majority vote (see Configuration).
- Counter: 16 bits. Cleared on every state entry; increments every cycle within START, DATA and STOP.
- Sample strobe: counter == half−1 in START; counter == divisor−1 in DATA and STOP.
- States and transitions:
  - IDLE: when rx_s==0, go to START.
  - START: at the strobe, if the sample is 0, go to DATA with bit index 0. If the sample is 1 (glitch), go to IDLE with no output.
  - DATA: at the strobe, shift[index] ← sample. After index 7, go to STOP; otherwise index+1.
  - STOP: at the strobe, data ← shift.
    - If the sample is 1: valid=1, go to IDLE.
    - If the sample is 0: framing_error=1, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This blocks false start detection during a break condition.
- valid and framing_error are registered. They are mutually exclusive and never high for two consecutive cycles.
- A new start bit is accepted in the first IDLE cycle after STOP, so frames back to back with no idle gap are received.
- Reset, any cycle, including mid-frame:
  - state=IDLE, counter=0, index=0, shift=0.
  - data=0x00, valid=0, framing_error=0, busy=0.
  - Synchroniser flops=1.
  - A frame in progress is discarded.

## Timing
- Let t0 be the rising edge at which s1 first captures rx=0.
  - rx_s=0 after edge t0+1.
  - IDLE→START at edge t0+2.
  - Start bit sampled at edge t0+2+half.
  - Data bit i sampled at edge t0+2+half+(i+1)·divisor.
  - Stop bit sampled at edge E = t0+2+half+9·divisor.
- valid or framing_error is high for exactly the cycle after edge E. data changes at edge E.
  - At defaults, E = t0+4125.
- busy rises after edge t0+2 and falls after edge E on a good frame. On a framing error, busy stays high until BREAK exits.
- Glitch rejection: a low pulse on rx_s shorter than half cycles returns to IDLE after edge t0+2+half. No strobe is produced.
- Throughput: one byte per 10·divisor cycles under continuous traffic.

## Configuration
- UART_RX_MAJORITY_EN
  - Defined: a 3-bit history of rx_s (current plus previous two cycles) is kept. The sample value is the 2-of-3 majority at the strobe edge. No added latency, so Timing is unchanged.
  - Undefined: the sample value is rx_s alone. The history register is not built.

## Test plan
- Frame 0x55 at defaults, rx idle 1 before and after:
  - data=0x55, valid high for one cycle after edge t0+4125.
  - framing_error stays 0; busy falls in the same cycle.
- rx low for 100 cycles, then high:
  - No valid and no framing_error; busy high then low after edge t0+219.
  - A following frame 0xA3 is received correctly.
- Frame 0x3C with stop bit 0, line held low 2000 more cycles:
  - framing_error pulses once; data=0x3C; valid stays 0.
  - busy stays high until rx_s returns to 1; no spurious second frame.
- Back-to-back frames 0x00 then 0xFF, no idle gap:
  - Two valid pulses exactly 4340 cycles apart, with data 0x00 then 0xFF.
- reset asserted for one cycle at the middle of data bit 3, line then idle:
  - Next cycle: all outputs 0, busy=0, no strobe for the aborted frame.
  - A subsequent frame 0x81 gives data=0x81 with valid.
- Frame 0xFF with rx forced 0 for one cycle at the bit-2 sample edge:
  - Macro defined: data=0xFF.
  - Macro undefined: data=0xFB.
  - valid pulses in both builds.
